// File: rtl/wasca_led_driver.sv
// wasca_led_driver
//   Output stage between the extra-LEDs PIO register and the board LED pins.
//   The steady pattern written by the CPU is dimmed by a global PWM duty and
//   overlaid with per-channel activity blinking: a rising edge on act_in opens
//   a timed window during which the LED is inverted on the shared blink phase.
//
// Ports
//   clk            : system clock
//   reset_n        : asynchronous active-low reset, clears every register
//   led_in         : steady LED pattern from the PIO out_port (clk domain)
//   act_in         : activity strobes, may be asynchronous, >=2 clk wide
//   brightness     : global PWM duty, 0 = off, all-ones = always on
//   led_out        : registered LED pin drive (polarity set by ACTIVE_LOW)
//   stretch_active : registered per-channel "blink window running" flag
module wasca_led_driver #(
  parameter int N_LEDS        = 5,
  parameter int PRESCALE      = 50000,
  parameter int STRETCH_TICKS = 50,
  parameter int BLINK_TICKS   = 25,
  parameter int PWM_BITS      = 8,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_LEDS-1:0]   led_in,
  input  logic [N_LEDS-1:0]   act_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   led_out,
  output logic [N_LEDS-1:0]   stretch_active
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]     r_prescale;
  logic                w_tick;
  logic [7:0]          r_blink_cnt;
  logic                r_blink_phase;
  logic [N_LEDS-1:0]   r_act_s1;
  logic [N_LEDS-1:0]   r_act_s2;
  logic [N_LEDS-1:0]   r_act_s3;
  logic [N_LEDS-1:0]   w_act_rise;
  logic [7:0]          r_stretch_cnt [N_LEDS];
  logic [N_LEDS-1:0]   w_cnt_nz;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_pwm_on;
  logic [N_LEDS-1:0]   r_led_reg;
  logic [N_LEDS-1:0]   w_lit;
  logic [N_LEDS-1:0]   r_led_out;
  logic [N_LEDS-1:0]   r_stretch_active;

  // One-clk tick on the last prescaler count; the counter wraps on that same cycle.
  assign w_tick = (r_prescale == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  // Free-running blink phase shared by all channels, toggling every BLINK_TICKS ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= 8'd0;
      r_blink_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == 8'(BLINK_TICKS - 1)) begin
        r_blink_cnt   <= 8'd0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  // act_in may be asynchronous: two flops to synchronise, a third for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_s1 <= '0;
      r_act_s2 <= '0;
      r_act_s3 <= '0;
    end else begin
      r_act_s1 <= act_in;
      r_act_s2 <= r_act_s1;
      r_act_s3 <= r_act_s2;
    end
  end

  assign w_act_rise = r_act_s2 & ~r_act_s3;

  // A fresh edge reloads the window even on a tick cycle, so retriggering always
  // restores the full STRETCH_TICKS rather than losing one to the decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_LEDS; i++) begin
        r_stretch_cnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (w_act_rise[i]) begin
          r_stretch_cnt[i] <= 8'(STRETCH_TICKS);
        end else if (w_tick && (r_stretch_cnt[i] != 8'd0)) begin
          r_stretch_cnt[i] <= r_stretch_cnt[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_cnt_nz = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      w_cnt_nz[i] = (r_stretch_cnt[i] != 8'd0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // All-ones brightness is forced on so full scale really means 100% duty.
  assign w_pwm_on = (brightness == '1) | (r_pwm_cnt < brightness);

  // Inside a window the blink phase inverts the steady state instead of replacing it.
  assign w_lit = r_led_reg ^ (w_cnt_nz & {N_LEDS{r_blink_phase}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_reg        <= '0;
      r_led_out        <= {N_LEDS{ACTIVE_LOW}};
      r_stretch_active <= '0;
    end else begin
      r_led_reg        <= led_in;
      r_led_out        <= {N_LEDS{ACTIVE_LOW}} ^ ({N_LEDS{w_pwm_on}} & w_lit);
      r_stretch_active <= w_cnt_nz;
    end
  end

  assign led_out        = r_led_out;
  assign stretch_active = r_stretch_active;

endmodule
